fan_speed_sequencer: RTL and testbench



---
 rtl/fan_speed_sequencer.sv | 169 ++++++++++++++++
 tb/tb_fan_speed_sequencer.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fan_speed_sequencer.sv
// fan_speed_sequencer: turns a single "set speed" request into the one-step
// up/down/update pulse protocol of fan_controller, confirming every step
// against the speed feedback, retrying steps that do not move and flagging
// a stuck fan through a sticky err.
// Optional feature macro: FAN_SEQ_STOP_SHORTCUT_EN -- when defined, a stop
// request from speed 2 or 3 uses the fan's both-lines-high stop in a single
// step instead of walking down one speed at a time.
module fan_speed_sequencer #(
  parameter int SETTLE_CYCLES = 2,
  parameter int MAX_RETRY     = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  input  logic [1:0] req_speed,
  output logic       req_ready,
  input  logic [1:0] fan_speed,
  output logic       fan_up,
  output logic       fan_down,
  output logic       fan_update,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES);
  localparam logic [3:0] RETRY_LIMIT = 4'(MAX_RETRY);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_PULSE,
    S_SETTLE,
    S_DONE
  } state_t;

  state_t     state_reg, state_next;
  logic [1:0] target_reg;
  logic [1:0] expected_reg;
  logic       up_reg, down_reg;
  logic [3:0] settle_reg;
  logic [3:0] retry_reg;
  logic       err_reg;

  logic       up_calc, down_calc;
  logic [1:0] expected_calc;
  logic       settle_last;
  logic [3:0] retry_inc;

  assign settle_last = (settle_reg == 4'd1);
  assign retry_inc   = retry_reg + 4'd1;

  // Step direction and expected landing speed, derived from live feedback in SETUP
  always_comb begin
    up_calc       = 1'b0;
    down_calc     = 1'b0;
    expected_calc = fan_speed;
`ifdef FAN_SEQ_STOP_SHORTCUT_EN
    if (target_reg == 2'd0 && fan_speed >= 2'd2) begin
      up_calc       = 1'b1;
      down_calc     = 1'b1;
      expected_calc = 2'd0;
    end else
`endif
    if (target_reg > fan_speed) begin
      up_calc       = 1'b1;
      expected_calc = fan_speed + 2'd1;
    end else if (target_reg < fan_speed) begin
      down_calc     = 1'b1;
      expected_calc = fan_speed - 2'd1;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_reg <= S_IDLE;
    else       state_reg <= state_next;
  end

  // Next-state logic: accept, step sequencing and settle-time verdict
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: begin
        if (req_valid) state_next = (req_speed == fan_speed) ? S_DONE : S_SETUP;
      end
      S_SETUP: state_next = S_PULSE;
      S_PULSE: state_next = S_SETTLE;
      S_SETTLE: begin
        if (settle_last) begin
          if (fan_speed == target_reg)        state_next = S_DONE;
          else if (fan_speed == expected_reg) state_next = S_SETUP;
          else if (retry_inc > RETRY_LIMIT)   state_next = S_DONE;
          else                                state_next = S_SETUP;
        end
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Request latch, direction hold, settle/retry counters and sticky error
  always_ff @(posedge clk) begin
    if (reset) begin
      target_reg   <= 2'd0;
      expected_reg <= 2'd0;
      up_reg       <= 1'b0;
      down_reg     <= 1'b0;
      settle_reg   <= 4'd0;
      retry_reg    <= 4'd0;
      err_reg      <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (req_valid) begin
            target_reg <= req_speed;
            retry_reg  <= 4'd0;
            err_reg    <= 1'b0;
          end
        end
        S_SETUP: begin
          up_reg       <= up_calc;
          down_reg     <= down_calc;
          expected_reg <= expected_calc;
        end
        S_PULSE: settle_reg <= SETTLE_LOAD;
        S_SETTLE: begin
          settle_reg <= settle_reg - 4'd1;
          if (settle_last && fan_speed != target_reg) begin
            if (fan_speed == expected_reg) begin
              retry_reg <= 4'd0;
            end else begin
              retry_reg <= retry_inc;
              if (retry_inc > RETRY_LIMIT) err_reg <= 1'b1;
            end
          end
        end
        S_DONE: begin
          up_reg   <= 1'b0;
          down_reg <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Moore outputs; SETUP drives the freshly computed direction, later phases hold it
  always_comb begin
    req_ready  = (state_reg == S_IDLE);
    busy       = (state_reg != S_IDLE);
    done       = (state_reg == S_DONE);
    err        = err_reg;
    fan_up     = 1'b0;
    fan_down   = 1'b0;
    fan_update = (state_reg == S_PULSE);
    case (state_reg)
      S_SETUP: begin
        fan_up   = up_calc;
        fan_down = down_calc;
      end
      S_PULSE, S_SETTLE: begin
        fan_up   = up_reg;
        fan_down = down_reg;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_fan_speed_sequencer.sv
// Bench for fan_speed_sequencer: a simple fan model answers the update
// pulses, a trajectory model predicts every output cycle by cycle, and
// directed requests pin completion cycle, pulse count and error.
module tb_fan_speed_sequencer;

  localparam int S  = 2;
  localparam int MR = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req_valid = 1'b0;
  logic [1:0] req_speed = 2'd0;
  logic       req_ready;
  logic [1:0] fan_spd = 2'd0;
  logic       fan_up, fan_down, fan_update, busy, done, err;

  logic       upd_d = 1'b0;
  logic       fan_load = 1'b0;
  logic [1:0] fan_load_val = 2'd0;
  logic       fan_stuck = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fan_speed_sequencer #(.SETTLE_CYCLES(S), .MAX_RETRY(MR)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_speed (req_speed),
    .req_ready (req_ready),
    .fan_speed (fan_spd),
    .fan_up    (fan_up),
    .fan_down  (fan_down),
    .fan_update(fan_update),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  // Fan: acts on the rising edge of update; both lines high means stop.
  function automatic logic [1:0] fan_step(input logic [1:0] s, input bit u, input bit d);
    if (u && d) return 2'd0;
    if (u) return (s == 2'd3) ? 2'd3 : s + 2'd1;
    if (d) return (s == 2'd0) ? 2'd0 : s - 2'd1;
    return s;
  endfunction

  always @(posedge clk) begin
    upd_d <= fan_update;
    if (fan_load) fan_spd <= fan_load_val;
    else if (fan_update && !upd_d && !fan_stuck) fan_spd <= fan_step(fan_spd, fan_up, fan_down);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // Expected record per cycle: {ready, busy, done, err, up, down, update}
  typedef logic [6:0] rec_t;
  rec_t q[$];
  logic m_err = 1'b0;

  function automatic rec_t mk(input bit dn, input bit e, input bit u, input bit d, input bit p);
    return {1'b0, 1'b1, dn, e, u, d, p};
  endfunction

  // Plays the whole request out against the fan model at accept time.
  task automatic build(input logic [1:0] t, input logic [1:0] s0, input bit stuck);
    logic [1:0] s;
    logic [1:0] ex;
    bit u, d, e;
    int retries;
    s = s0; e = 0; retries = 0;
    if (t != s) begin
      for (int step = 0; step < 32; step++) begin
        u  = (t > s);
        d  = (t < s);
        ex = u ? s + 2'd1 : s - 2'd1;
`ifdef FAN_SEQ_STOP_SHORTCUT_EN
        if (t == 2'd0 && s >= 2'd2) begin u = 1; d = 1; ex = 2'd0; end
`endif
        q.push_back(mk(0, 0, u, d, 0));
        q.push_back(mk(0, 0, u, d, 1));
        for (int i = 0; i < S; i++) q.push_back(mk(0, 0, u, d, 0));
        if (!stuck) s = fan_step(s, u, d);
        if (s == t) break;
        if (s == ex) retries = 0;
        else begin
          retries++;
          if (retries > MR) begin e = 1; break; end
        end
      end
    end
    q.push_back(mk(1, e, 0, 0, 0));
  endtask

  // Model advance at each edge, then compare all outputs 1 time unit later
  initial begin : model
    bit   idle_prev;
    rec_t r, expv;
    forever begin
      @(posedge clk);
      if (reset) begin
        q.delete();
        m_err = 1'b0;
      end else begin
        idle_prev = (q.size() == 0);
        if (!idle_prev) begin
          r = q.pop_front();
          if (q.size() == 0) m_err = r[3];
        end
        if (idle_prev && req_valid) build(req_speed, fan_spd, fan_stuck);
      end
      #1;
      expv = (q.size() != 0) ? q[0] : {1'b1, 1'b0, 1'b0, m_err, 3'b000};
      check("cycle_outputs", {req_ready, busy, done, err, fan_up, fan_down, fan_update}, expv);
    end
  end

  task automatic fan_set(input logic [1:0] v);
    @(negedge clk);
    fan_load = 1'b1;
    fan_load_val = v;
    @(negedge clk);
    fan_load = 1'b0;
  endtask

  // Issue one request; cycle k counts from the accept edge (cycle 0).
  task automatic do_req(input string name, input logic [1:0] spd, input int exp_done,
                        input int exp_pulses, input bit exp_err, input bit hold,
                        input logic [1:0] hold_spd);
    int w, k, pulses;
    bit got;
    @(negedge clk);
    req_valid = 1'b1;
    req_speed = spd;
    w = 0;
    while (!req_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (w >= 100) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_accept: req_ready never high within 100 cycles", name);
    end
    @(posedge clk);
    k = 0; pulses = 0; got = 0;
    while (k < 200 && !got) begin
      #1;
      k++;
      if (k == 1) req_valid = 1'b0;
      if (hold && k == 3) begin
        req_valid = 1'b1;
        req_speed = hold_spd;
      end
      if (fan_update) pulses++;
      if (done) got = 1;
      else @(posedge clk);
    end
    check({name, "_done_cycle"}, k, exp_done);
    check({name, "_pulses"}, pulses, exp_pulses);
    check({name, "_err"}, err, exp_err);
    @(posedge clk);
    #1;
    check({name, "_ready_after_done"}, req_ready, 1);
  endtask

  initial begin : stim
    repeat (3) @(negedge clk);
    check("reset_ready", req_ready, 1);
    check("reset_busy", busy, 0);
    check("reset_err", err, 0);
    check("reset_outs", {done, fan_up, fan_down, fan_update}, 0);
    reset = 1'b0;

    fan_set(2'd0);
    do_req("up_0_to_3", 2'd3, 13, 3, 0, 0, 2'd0);

    fan_set(2'd1);
    do_req("noop_1", 2'd1, 1, 0, 0, 0, 2'd0);

    fan_set(2'd3);
`ifdef FAN_SEQ_STOP_SHORTCUT_EN
    do_req("stop_from_3", 2'd0, 5, 1, 0, 0, 2'd0);
`else
    do_req("stop_from_3", 2'd0, 13, 3, 0, 0, 2'd0);
`endif

    fan_set(2'd1);
    @(negedge clk);
    fan_stuck = 1'b1;
    do_req("stuck_at_1", 2'd2, 17, 4, 1, 0, 2'd0);
    @(negedge clk);
    fan_stuck = 1'b0;
    do_req("err_clear", 2'd1, 1, 0, 0, 0, 2'd0);

    // Reset while the update pulse of a 0->2 move is high
    fan_set(2'd0);
    @(negedge clk);
    req_valid = 1'b1;
    req_speed = 2'd2;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    check("abort_pulse_high", fan_update, 1);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("abort_update", fan_update, 0);
    check("abort_busy", busy, 0);
    check("abort_ready", req_ready, 1);
    check("abort_done", done, 0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      check("abort_no_done", done, 0);
    end

    // New request held while busy is only taken once req_ready returns
    fan_set(2'd0);
    do_req("busy_first", 2'd2, 9, 2, 0, 1, 2'd0);
`ifdef FAN_SEQ_STOP_SHORTCUT_EN
    do_req("busy_second", 2'd0, 5, 1, 0, 0, 2'd0);
`else
    do_req("busy_second", 2'd0, 9, 2, 0, 0, 2'd0);
`endif

    repeat (3) @(posedge clk);
    #2;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
